// File: rtl/semi_input_conditioner.sv
// Input stage for the semi-auto driving controller: synchronises and debounces buttons and
// detector lines, and turns each fresh button press into a one-hot move command of fixed length.
module semi_input_conditioner #(
  parameter int DEBOUNCE_CNT = 10,
  parameter int DET_FILTER   = 3,
  parameter int CMD_HOLD     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn_forward,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_backward,
  input  logic [3:0] detector_raw,
  output logic       move_forward,
  output logic       move_left,
  output logic       move_right,
  output logic       move_backward,
  output logic [3:0] detector,
  output logic       cmd_busy
);

  localparam int MAXN = (DEBOUNCE_CNT > DET_FILTER) ? DEBOUNCE_CNT : DET_FILTER;
  localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int HW   = (CMD_HOLD > 1) ? $clog2(CMD_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(CMD_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REL_WAIT} state_t;

  // Bits 3:0 are the buttons (fwd, left, right, back), bits 7:4 the detector lines.
  logic [7:0] w_raw;
  logic [7:0] r_s1;
  logic [7:0] r_s2;
  logic [7:0] w_stable;

  assign w_raw = {detector_raw, btn_backward, btn_right, btn_left, btn_forward};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // The stable level flips only after N consecutive edges in which the synchronised bit differs.
  for (genvar g = 0; g < 8; g++) begin : g_filt
    localparam int N = (g < 4) ? DEBOUNCE_CNT : DET_FILTER;
    localparam logic [CW-1:0] LIM = CW'(N - 1);
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else if (r_s2[g] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LIM) begin
        r_level <= r_s2[g];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign w_stable[g] = r_level;
  end

  logic [3:0] w_btn;
  logic [3:0] r_prev;
  logic [3:0] w_rise;
  logic [3:0] w_sel;

  assign w_btn  = w_stable[3:0];
  assign w_rise = w_btn & ~r_prev;

  always_comb begin
    w_sel = 4'b0000;
    if (w_rise[0])      w_sel = 4'b0001;
    else if (w_rise[1]) w_sel = 4'b0010;
    else if (w_rise[2]) w_sel = 4'b0100;
    else if (w_rise[3]) w_sel = 4'b1000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '0;
    else        r_prev <= w_btn;
  end

  state_t        r_state;
  logic [3:0]    r_move;
  logic [HW-1:0] r_hold;
  logic          r_busy;

  // Rises seen outside IDLE are simply dropped; REL_WAIT forces a full release before re-arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_move  <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_move  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_rise) begin
            r_state <= S_HOLD;
            r_move  <= w_sel;
            r_hold  <= HOLD_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (r_hold == '0) begin
            r_state <= S_REL_WAIT;
            r_move  <= '0;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        S_REL_WAIT: begin
          if (w_btn == 4'b0000) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_move  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign move_forward  = r_move[0];
  assign move_left     = r_move[1];
  assign move_right    = r_move[2];
  assign move_backward = r_move[3];
  assign detector      = w_stable[7:4];
  assign cmd_busy      = r_busy;

endmodule

// File: tb/tb_semi_input_conditioner.sv
// Directed bench for semi_input_conditioner: a sample-history model of the filters plus a
// command-level model of the FSM, checked every cycle, with hand-computed literal pins.
module tb_semi_input_conditioner;
  localparam int DB = 4;
  localparam int DF = 3;
  localparam int CH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       bf = 1'b0, bl = 1'b0, br = 1'b0, bb = 1'b0;
  logic [3:0] det_raw = 4'b0000;
  logic       mf, ml, mr, mb;
  logic [3:0] det;
  logic       busy;

  always #5 clk = ~clk;

  semi_input_conditioner #(.DEBOUNCE_CNT(DB), .DET_FILTER(DF), .CMD_HOLD(CH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_forward(bf), .btn_left(bl), .btn_right(br), .btn_backward(bb),
    .detector_raw(det_raw),
    .move_forward(mf), .move_left(ml), .move_right(mr), .move_backward(mb),
    .detector(det), .cmd_busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: h[i] is the raw vector sampled i edges ago (h[0] = this edge).
  logic [7:0] h [16];
  logic [7:0] m_stable;
  logic [3:0] m_prev;
  bit         m_busy;
  int         m_dir;
  int         m_remain;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) h[i] = 8'h00;
    m_stable = 8'h00;
    m_prev   = 4'h0;
    m_busy   = 1'b0;
    m_dir    = 0;
    m_remain = 0;
  endtask

  function automatic logic [3:0] exp_move();
    if (m_busy && m_remain > 0) return 4'(1 << m_dir);
    return 4'b0000;
  endfunction

  task automatic model_step();
    logic [3:0] deb;
    logic [3:0] rise;
    logic [7:0] nxt;
    bit         all_diff;
    int         n;
    if (!rst_n) begin
      model_clear();
      return;
    end
    deb  = m_stable[3:0];
    rise = deb & ~m_prev;
    if (!enable) begin
      m_busy   = 1'b0;
      m_remain = 0;
    end else if (!m_busy) begin
      if (rise != 4'b0000) begin
        for (int d = 3; d >= 0; d--) if (rise[d]) m_dir = d;
        m_remain = CH;
        m_busy   = 1'b1;
      end
    end else if (m_remain > 0) begin
      m_remain--;
    end else if (deb == 4'b0000) begin
      m_busy = 1'b0;
    end
    m_prev = deb;
    for (int i = 15; i > 0; i--) h[i] = h[i-1];
    h[0] = {det_raw, bb, br, bl, bf};
    // A level flips once the last N synchronised samples (two edges old) all disagree with it.
    nxt = m_stable;
    for (int b = 0; b < 8; b++) begin
      n = (b < 4) ? DB : DF;
      all_diff = 1'b1;
      for (int i = 0; i < n; i++) if (h[2+i][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) nxt[b] = ~m_stable[b];
    end
    m_stable = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {mb, mr, ml, mf, busy, det}, 8'h00);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_move", {4'h0, mb, mr, ml, mf}, {4'h0, exp_move()});
        check("model_det", {4'h0, det}, {4'h0, m_stable[7:4]});
        check("model_busy", {7'h0, busy}, {7'h0, m_busy});
        check("onehot", {7'h0, ($countones({mb, mr, ml, mf}) > 1)}, 8'h00);
      end
    end
  end

  initial begin
    int pulses;
    logic last_mb;
    model_clear();
    chk_en = 1'b1;

    // 1: reset with random inputs, then release with inputs at 0
    for (int i = 0; i < 5; i++) begin
      {bf, bl, br, bb} = 4'($urandom);
      det_raw = 4'($urandom);
      enable  = 1'($urandom);
      tick();
      check_all_zero("reset_outputs");
    end
    {bf, bl, br, bb} = 4'h0;
    det_raw = 4'h0;
    enable  = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero("post_reset_idle");
    end

    // 2: left held 30 cycles
    bl = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e <= 11) check("left_pulse", {7'h0, ml}, {7'h0, (e >= 7 && e <= 9)});
      if (e == 36) check("left_busy_hold", {7'h0, busy}, 8'h01);
      if (e == 37) check("left_busy_clear", {7'h0, busy}, 8'h00);
      if (e == 30) bl = 1'b0;
    end

    // 3: short forward glitch and short detector glitch
    bf = 1'b1;
    det_raw = 4'b0001;
    tick();
    tick();
    det_raw = 4'b0000;
    tick();
    bf = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_busy", {7'h0, busy}, 8'h00);
      check("glitch_det", {4'h0, det}, 8'h00);
    end

    // 4: right and backward together, forward pressed during HOLD
    br = 1'b1;
    bb = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e <= 12) begin
        check("simul_right", {7'h0, mr}, {7'h0, (e >= 7 && e <= 9)});
        check("simul_back", {7'h0, mb}, 8'h00);
      end
      check("ignored_fwd", {7'h0, mf}, 8'h00);
      if (e == 8) bf = 1'b1;
      if (e == 15) {bf, br, bb} = 3'b000;
    end

    // 5: backward held 40 cycles, released, pressed again; detector steady pattern
    det_raw = 4'b1011;
    bb = 1'b1;
    pulses = 0;
    last_mb = 1'b0;
    for (int e = 1; e <= 76; e++) begin
      tick();
      if (mb && !last_mb) pulses++;
      last_mb = mb;
      if (e == 4) check("det_before", {4'h0, det}, 8'h00);
      if (e == 5) check("det_1011", {4'h0, det}, 8'h0B);
      if (e == 40) begin
        check("back_one_pulse", 8'(pulses), 8'd1);
        bb = 1'b0;
      end
      if (e == 52) bb = 1'b1;
      if (e == 64) bb = 1'b0;
    end
    check("back_two_pulses", 8'(pulses), 8'd2);

    // 6a: enable dropped during HOLD, re-enabled with button still held
    bf = 1'b1;
    ticks(8);
    check("fwd_in_hold", {7'h0, mf}, 8'h01);
    enable = 1'b0;
    tick();
    check("disable_move", {4'h0, mb, mr, ml, mf}, 8'h00);
    check("disable_busy", {7'h0, busy}, 8'h00);
    ticks(5);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reenable_no_cmd", {7'h0, mf}, 8'h00);
    end
    bf = 1'b0;
    ticks(10);
    check("reenable_idle", {7'h0, busy}, 8'h00);

    // 6b: asynchronous reset mid-HOLD
    bl = 1'b1;
    ticks(8);
    check("left_in_hold", {7'h0, ml}, 8'h01);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_reset_move", {4'h0, mb, mr, ml, mf}, 8'h00);
    check("async_reset_busy", {7'h0, busy}, 8'h00);
    bl = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("post_reset_no_cmd", {6'h0, ml, busy}, 8'h00);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
